// File: rtl/mem_arb_pkg.sv
// Shared types for the memory-controller channel arbiter: request kind, block widths and the
// per-read tag that routes a response back to its channel.
package mem_arb_pkg;

  localparam int unsigned MAIN_MEM_ADDR_W = 26;
  localparam int unsigned MAIN_MEM_BLOCK_W = 512;
  // Tag channel-id field is sized for up to 16 channels.
  localparam int unsigned ARB_CH_ID_W = 4;

  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } req_type_t;

  typedef logic [MAIN_MEM_ADDR_W-1:0]  main_mem_block_addr_t;
  typedef logic [MAIN_MEM_BLOCK_W-1:0] block_data_t;

  typedef struct packed {
    logic [ARB_CH_ID_W-1:0] ch_id;
    logic                   squash;
  } arb_tag_t;

endpackage

// File: rtl/mem_arb_tag_fifo.sv
// In-order tag FIFO for outstanding reads; flush marks every live entry of a channel as squashed.
module mem_arb_tag_fifo
  import mem_arb_pkg::*;
#(
  parameter int unsigned Depth = 4,
  parameter int unsigned NumCh = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [ARB_CH_ID_W-1:0]   push_ch_i,
  input  logic                     pop_i,
  input  logic [NumCh-1:0]         flush_i,
  output arb_tag_t                 head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(Depth):0]   count_o
);

  localparam int unsigned AW = $clog2(Depth);

  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] count;
  logic        push_en, pop_en;
  arb_tag_t    mem_q [Depth];
  arb_tag_t    mem_d [Depth];

  assign count   = wr_q - rd_q;
  assign empty_o = (count == '0);
  assign full_o  = (count == (AW + 1)'(Depth));
  assign count_o = count;
  assign head_o  = mem_q[rd_q[AW-1:0]];

  assign pop_en  = pop_i & ~empty_o;
  assign push_en = push_i & (~full_o | pop_en);

  always_comb begin
    logic [AW-1:0] off;
    mem_d = mem_q;
    off   = '0;
    for (int i = 0; i < Depth; i++) begin
      off = AW'(i) - rd_q[AW-1:0];
      if ({1'b0, off} < count) begin
        for (int c = 0; c < NumCh; c++) begin
          if (flush_i[c] && (mem_q[i].ch_id == ARB_CH_ID_W'(c))) mem_d[i].squash = 1'b1;
        end
      end
    end
    // Pushed after the squash pass so a read accepted during a flush stays live.
    if (push_en) mem_d[wr_q[AW-1:0]] = '{ch_id: push_ch_i, squash: 1'b0};
    wr_d = push_en ? wr_q + 1'b1 : wr_q;
    rd_d = pop_en ? rd_q + 1'b1 : rd_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/mem_ctrl_arbiter.sv
// Round-robin N-channel arbiter onto one main-memory port, with in-order read-response routing,
// bounded outstanding reads and per-channel squash of in-flight reads.
module mem_ctrl_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned N_CH      = 2,
  parameter int unsigned ADDR_W    = 26,
  parameter int unsigned BLOCK_W   = 512,
  parameter int unsigned MAX_OUTST = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_CH-1:0]               ch_req_valid,
  input  logic [N_CH-1:0]               ch_req_type,
  input  logic [N_CH*ADDR_W-1:0]        ch_req_block_addr,
  input  logic [N_CH*BLOCK_W-1:0]       ch_req_block_data,
  output logic [N_CH-1:0]               ch_req_ready,
  output logic [N_CH-1:0]               ch_resp_valid,
  output logic [BLOCK_W-1:0]            ch_resp_block_data,
  input  logic [N_CH-1:0]               ch_flush,
  output logic                          mem_req_valid,
  output logic                          mem_req_type,
  output logic [ADDR_W-1:0]             mem_req_block_addr,
  output logic [BLOCK_W-1:0]            mem_req_block_data,
  input  logic                          mem_req_ready,
  input  logic                          mem_resp_valid,
  input  logic [BLOCK_W-1:0]            mem_resp_block_data,
  output logic [$clog2(MAX_OUTST):0]    outst_count,
  output logic                          err_unexpected_resp
);

  localparam int unsigned ChW = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic [ChW-1:0]     rr_q, rr_d;
  logic               mem_valid_q, mem_valid_d;
  req_type_t          mem_type_q, mem_type_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [BLOCK_W-1:0] mem_data_q, mem_data_d;
  logic               err_q, err_d;

  logic               fifo_full, fifo_empty, fifo_pop, fifo_push;
  arb_tag_t           fifo_head;
  logic               can_load, read_ok, accept;
  logic [N_CH-1:0]    eligible;
  logic               hi_valid, lo_valid, grant_valid;
  logic [ChW-1:0]     hi_idx, lo_idx, grant_idx;
  req_type_t          sel_type;
  logic [ADDR_W-1:0]  sel_addr;
  logic [BLOCK_W-1:0] sel_data;
  logic               head_flushed;

  assign can_load = ~mem_valid_q | mem_req_ready;
  assign fifo_pop = mem_resp_valid & ~fifo_empty;
  assign read_ok  = ~fifo_full | fifo_pop;

  // Rotating priority: lowest eligible index at or above rr_q, else lowest eligible overall.
  always_comb begin
    hi_valid = 1'b0;
    hi_idx   = '0;
    lo_valid = 1'b0;
    lo_idx   = '0;
    for (int c = 0; c < N_CH; c++) begin
      eligible[c] = ch_req_valid[c] & ((req_type_t'(ch_req_type[c]) == WRITE) | read_ok);
    end
    for (int c = N_CH - 1; c >= 0; c--) begin
      if (eligible[c]) begin
        lo_valid = 1'b1;
        lo_idx   = ChW'(c);
        if (ChW'(c) >= rr_q) begin
          hi_valid = 1'b1;
          hi_idx   = ChW'(c);
        end
      end
    end
    grant_valid = hi_valid | lo_valid;
    grant_idx   = hi_valid ? hi_idx : lo_idx;
  end

  assign accept = can_load & grant_valid & ~rst;

  always_comb begin
    sel_type = READ;
    sel_addr = '0;
    sel_data = '0;
    for (int c = 0; c < N_CH; c++) begin
      ch_req_ready[c] = accept & (grant_idx == ChW'(c));
      if (grant_idx == ChW'(c)) begin
        sel_type = req_type_t'(ch_req_type[c]);
        sel_addr = ch_req_block_addr[c*ADDR_W +: ADDR_W];
        sel_data = ch_req_block_data[c*BLOCK_W +: BLOCK_W];
      end
    end
  end

  assign fifo_push = accept & (sel_type == READ);

  always_comb begin
    mem_valid_d = mem_valid_q;
    mem_type_d  = mem_type_q;
    mem_addr_d  = mem_addr_q;
    mem_data_d  = mem_data_q;
    rr_d        = rr_q;
    if (accept) begin
      mem_valid_d = 1'b1;
      mem_type_d  = sel_type;
      mem_addr_d  = sel_addr;
      mem_data_d  = sel_data;
      rr_d        = (grant_idx == ChW'(N_CH - 1)) ? '0 : grant_idx + 1'b1;
    end else if (mem_req_ready) begin
      mem_valid_d = 1'b0;
    end
    err_d = err_q | (mem_resp_valid & fifo_empty);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q        <= '0;
      mem_valid_q <= 1'b0;
      mem_type_q  <= READ;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      rr_q        <= rr_d;
      mem_valid_q <= mem_valid_d;
      mem_type_q  <= mem_type_d;
      mem_addr_q  <= mem_addr_d;
      mem_data_q  <= mem_data_d;
      err_q       <= err_d;
    end
  end

  mem_arb_tag_fifo #(
    .Depth (MAX_OUTST),
    .NumCh (N_CH)
  ) u_tag_fifo (
    .clk_i     (clk),
    .rst_i     (rst),
    .push_i    (fifo_push),
    .push_ch_i (ARB_CH_ID_W'(grant_idx)),
    .pop_i     (fifo_pop),
    .flush_i   (ch_flush),
    .head_o    (fifo_head),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .count_o   (outst_count)
  );

  // A response for a channel flushed in the same cycle is dropped too.
  always_comb begin
    head_flushed = 1'b0;
    for (int c = 0; c < N_CH; c++) begin
      if (ch_flush[c] && (fifo_head.ch_id == ARB_CH_ID_W'(c))) head_flushed = 1'b1;
    end
    for (int c = 0; c < N_CH; c++) begin
      ch_resp_valid[c] = fifo_pop & ~fifo_head.squash & ~head_flushed & ~rst &
                         (fifo_head.ch_id == ARB_CH_ID_W'(c));
    end
  end

  assign ch_resp_block_data  = mem_resp_block_data;
  assign mem_req_valid       = mem_valid_q;
  assign mem_req_type        = mem_type_q;
  assign mem_req_block_addr  = mem_addr_q;
  assign mem_req_block_data  = mem_data_q;
  assign err_unexpected_resp = err_q;

endmodule
